// File: rtl/instr_exec_ctrl_if.sv
// Bundle between the execute/write-back controller, its instruction source and the 8x8 register file.
// The master modport is the controller's side of every signal.
interface instr_exec_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int WA_W   = 3,
  parameter int RA_W   = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [RA_W-1:0]   register_address1;
  logic [RA_W-1:0]   register_address2;
  logic [DATA_W-1:0] register_data1;
  logic [DATA_W-1:0] register_data2;
  logic              write_enable;
  logic [WA_W-1:0]   write_address;
  logic [DATA_W-1:0] write_data;
  logic              done;
  logic              illegal;
  logic [15:0]       retired_count;

  modport master (
    input  instr_valid, instr, register_data1, register_data2,
    output instr_ready, register_address1, register_address2,
           write_enable, write_address, write_data, done, illegal, retired_count
  );

  modport slave (
    output instr_valid, instr, register_data1, register_data2,
    input  instr_ready, register_address1, register_address2,
           write_enable, write_address, write_data, done, illegal, retired_count
  );
endinterface

// File: rtl/instr_exec_ctrl.sv
// Four-state RV32I ALU execute/write-back controller feeding an 8x8 register file.
// Define INSTR_COUNTER_EN to build the 16-bit retired-instruction counter.
module instr_exec_ctrl #(
  parameter int DATA_W = 8,
  parameter int WA_W   = 3,
  parameter int RA_W   = 4
) (
  input  logic              clock_reg,
  input  logic              reset,
  instr_exec_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WBACK} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI} op_t;

  state_t            state_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] op1_q, op2_q, op2_d;
  op_t               op_q, op_d;
  logic              legal_q, legal_d;
  logic              ready_q, we_q, done_q, ill_q;
  logic [RA_W-1:0]   ra1_q, ra2_q;
  logic [WA_W-1:0]   wa_q;
  logic [DATA_W-1:0] res_q;
  logic              rd_nz;

  function automatic logic [DATA_W-1:0] alu(input op_t op, input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa, sb;
    logic [DATA_W-1:0]        r;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      OP_ADD, OP_ADDI: r = a + b;
      OP_SUB:          r = a - b;
      OP_AND:          r = a & b;
      OP_OR:           r = a | b;
      OP_SLT:          r = {{(DATA_W-1){1'b0}}, (sa < sb)};
      default:         r = '0;
    endcase
    return r;
  endfunction

  assign rd_nz = |ir_q[11:7];

  // Register fields wider than the 8-entry file make an otherwise valid encoding illegal.
  always_comb begin
    op_d    = OP_ADD;
    legal_d = 1'b0;
    op2_d   = bus.register_data2;
    if (ir_q[6:0] == 7'b0110011) begin
      case ({ir_q[31:25], ir_q[14:12]})
        10'b0000000_000: begin op_d = OP_ADD; legal_d = 1'b1; end
        10'b0100000_000: begin op_d = OP_SUB; legal_d = 1'b1; end
        10'b0000000_111: begin op_d = OP_AND; legal_d = 1'b1; end
        10'b0000000_110: begin op_d = OP_OR;  legal_d = 1'b1; end
        10'b0000000_010: begin op_d = OP_SLT; legal_d = 1'b1; end
        default:         legal_d = 1'b0;
      endcase
      if (ir_q[24:23] != 2'b00) legal_d = 1'b0;
    end else if (ir_q[6:0] == 7'b0010011 && ir_q[14:12] == 3'b000) begin
      op_d    = OP_ADDI;
      legal_d = 1'b1;
      op2_d   = ir_q[20 +: DATA_W];
    end
    if (ir_q[11:10] != 2'b00 || ir_q[19:18] != 2'b00) legal_d = 1'b0;
  end

  always_ff @(posedge clock_reg) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      op_q    <= OP_ADD;
      legal_q <= 1'b0;
      ready_q <= 1'b1;
      ra1_q   <= '0;
      ra2_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.instr_valid) begin
            ir_q    <= bus.instr;
            ra1_q   <= RA_W'(bus.instr[17:15]);
            ra2_q   <= RA_W'(bus.instr[22:20]);
            ready_q <= 1'b0;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          op1_q   <= bus.register_data1;
          op2_q   <= op2_d;
          op_q    <= op_d;
          legal_q <= legal_d;
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          res_q   <= (legal_q && rd_nz) ? alu(op_q, op1_q, op2_q) : '0;
          we_q    <= legal_q && rd_nz;
          wa_q    <= ir_q[7 +: WA_W];
          done_q  <= 1'b1;
          ill_q   <= !legal_q;
          state_q <= WBACK;
        end
        WBACK: begin
          we_q    <= 1'b0;
          wa_q    <= '0;
          res_q   <= '0;
          done_q  <= 1'b0;
          ill_q   <= 1'b0;
          ra1_q   <= '0;
          ra2_q   <= '0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.instr_ready       = ready_q;
  assign bus.register_address1 = ra1_q;
  assign bus.register_address2 = ra2_q;
  assign bus.write_enable      = we_q;
  assign bus.write_address     = wa_q;
  assign bus.write_data        = res_q;
  assign bus.done              = done_q;
  assign bus.illegal           = ill_q;

`ifdef INSTR_COUNTER_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clock_reg) begin
    if (reset)                 cnt_q <= '0;
    else if (done_q && !ill_q) cnt_q <= cnt_q + 16'd1;
  end

  assign bus.retired_count = cnt_q;
`else
  assign bus.retired_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_exec_ctrl.sv
// Self-checking bench for instr_exec_ctrl: directed vector table, multi-cycle corner sequences
// and randomized instructions checked against a field-level reference model.
module tb_instr_exec_ctrl;

  logic clk;
  logic rst;

  instr_exec_ctrl_if #(.DATA_W(8), .WA_W(3), .RA_W(4)) bus ();

  instr_exec_ctrl #(.DATA_W(8), .WA_W(3), .RA_W(4)) dut (
    .clock_reg (clk),
    .reset     (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rf [8];
  assign bus.register_data1 = rf[bus.register_address1[2:0]];
  assign bus.register_data2 = rf[bus.register_address2[2:0]];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = 16'h0000;

  typedef struct {
    logic       ill;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
  } exp_t;

  typedef struct {
    logic [31:0] ir;
    logic [7:0]  v1;
    logic [7:0]  v2;
    logic        ill;
    logic        we;
    logic [2:0]  wa;
    logic [7:0]  wd;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: decode straight from the instruction fields against the current register file.
  function automatic exp_t model(input logic [31:0] ir);
    exp_t       e;
    logic [7:0] a, b, imm;
    logic       ok, rt;
    int         sa, sb;
    a   = rf[ir[17:15]];
    b   = rf[ir[22:20]];
    imm = ir[27:20];
    sa  = $signed(a);
    sb  = $signed(b);
    rt  = (ir[6:0] == 7'h33);
    ok  = 1'b1;
    e.wd = 8'h00;
    if (rt && ir[31:25] == 7'h00 && ir[14:12] == 3'd0)      e.wd = 8'(a + b);
    else if (rt && ir[31:25] == 7'h20 && ir[14:12] == 3'd0) e.wd = 8'(a - b);
    else if (rt && ir[31:25] == 7'h00 && ir[14:12] == 3'd7) e.wd = a & b;
    else if (rt && ir[31:25] == 7'h00 && ir[14:12] == 3'd6) e.wd = a | b;
    else if (rt && ir[31:25] == 7'h00 && ir[14:12] == 3'd2) e.wd = (sa < sb) ? 8'd1 : 8'd0;
    else if (ir[6:0] == 7'h13 && ir[14:12] == 3'd0)         e.wd = 8'(a + imm);
    else ok = 1'b0;
    if (ir[11:7] > 5'd7 || ir[19:15] > 5'd7) ok = 1'b0;
    if (rt && ir[24:20] > 5'd7) ok = 1'b0;
    e.ill = !ok;
    e.we  = ok && (ir[11:7] != 5'd0);
    e.wa  = ir[9:7];
    return e;
  endfunction

  function automatic logic [4:0] rfld();
    if ($urandom_range(0, 9) > 7) return 5'($urandom_range(8, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0] rd, rs1, rs2;
    rd  = rfld();
    rs1 = rfld();
    rs2 = rfld();
    case ($urandom_range(0, 7))
      0:       return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
      1:       return {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
      2:       return {7'h00, rs2, rs1, 3'b111, rd, 7'h33};
      3:       return {7'h00, rs2, rs1, 3'b110, rd, 7'h33};
      4:       return {7'h00, rs2, rs1, 3'b010, rd, 7'h33};
      5:       return {12'($urandom), rs1, 3'b000, rd, 7'h13};
      6:       return 32'($urandom);
      default: return {7'h01, rs2, rs1, 3'($urandom), rd, 7'h33};
    endcase
  endfunction

  // Called and returns at a negedge with the controller idle.
  task automatic run_instr(input logic [31:0] ir, input logic ill, input logic we,
                           input logic [2:0] wa, input logic [7:0] wd, input string tag);
    int t = 0;
    while (bus.instr_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, ".ready_wait"}, 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = ir;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk({tag, ".dec_ready"}, 32'(bus.instr_ready), 32'd0);
    chk({tag, ".dec_ra1"},   32'(bus.register_address1), 32'({1'b0, ir[17:15]}));
    chk({tag, ".dec_ra2"},   32'(bus.register_address2), 32'({1'b0, ir[22:20]}));
    chk({tag, ".dec_done"},  32'({bus.done, bus.illegal, bus.write_enable}), 32'd0);
    @(negedge clk);
    chk({tag, ".ex_done"},   32'({bus.done, bus.illegal, bus.write_enable}), 32'd0);
    chk({tag, ".ex_ready"},  32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".wb_done"},   32'(bus.done), 32'd1);
    chk({tag, ".wb_ill"},    32'(bus.illegal), 32'(ill));
    chk({tag, ".wb_we"},     32'(bus.write_enable), 32'(we));
    chk({tag, ".wb_addr"},   32'(bus.write_address), 32'(wa));
    if (we) begin
      chk({tag, ".wb_data"}, 32'(bus.write_data), 32'(wd));
      rf[wa] = wd;
    end
    if (!ill) exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    chk({tag, ".idle_done"}, 32'({bus.done, bus.illegal, bus.write_enable}), 32'd0);
    chk({tag, ".idle_ready"}, 32'(bus.instr_ready), 32'd1);
`ifdef INSTR_COUNTER_EN
    chk({tag, ".count"}, 32'(bus.retired_count), 32'(exp_cnt));
`else
    chk({tag, ".count"}, 32'(bus.retired_count), 32'd0);
`endif
  endtask

  logic [31:0] b2b_ir [4];
  logic [2:0]  b2b_wa [4];
  logic [7:0]  b2b_wd [4];
  int          acc [4];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   k, w;
    logic accepting;

    tbl[0]  = '{32'h002081B3, 8'h05, 8'h03, 1'b0, 1'b1, 3'd3, 8'h08};
    tbl[1]  = '{32'h40208233, 8'h03, 8'h05, 1'b0, 1'b1, 3'd4, 8'hFE};
    tbl[2]  = '{32'h0020A2B3, 8'hFE, 8'h01, 1'b0, 1'b1, 3'd5, 8'h01};
    tbl[3]  = '{32'h7FF08313, 8'h02, 8'h00, 1'b0, 1'b1, 3'd6, 8'h01};
    tbl[4]  = '{32'h00100013, 8'h44, 8'h55, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[5]  = '{32'h022081B3, 8'h05, 8'h03, 1'b1, 1'b0, 3'd3, 8'h00};
    tbl[6]  = '{32'h002084B3, 8'h05, 8'h03, 1'b1, 1'b0, 3'd1, 8'h00};
    tbl[7]  = '{32'h0020F3B3, 8'hF0, 8'h3C, 1'b0, 1'b1, 3'd7, 8'h30};
    tbl[8]  = '{32'h0020E3B3, 8'hF0, 8'h0C, 1'b0, 1'b1, 3'd7, 8'hFC};
    tbl[9]  = '{32'h0020A2B3, 8'h01, 8'hFE, 1'b0, 1'b1, 3'd5, 8'h00};
    tbl[10] = '{32'h009081B3, 8'h05, 8'h03, 1'b1, 1'b0, 3'd3, 8'h00};
    tbl[11] = '{32'h01908313, 8'h10, 8'h77, 1'b0, 1'b1, 3'd6, 8'h29};
    tbl[12] = '{32'h40208233, 8'h00, 8'h01, 1'b0, 1'b1, 3'd4, 8'hFF};
    tbl[13] = '{32'h00140313, 8'h10, 8'h00, 1'b1, 1'b0, 3'd6, 8'h00};
    tbl[14] = '{32'h002081B7, 8'h05, 8'h03, 1'b1, 1'b0, 3'd3, 8'h00};
    tbl[15] = '{32'h4020F3B3, 8'h05, 8'h03, 1'b1, 1'b0, 3'd7, 8'h00};

    b2b_ir = '{32'h00108093, 32'h00208113, 32'h00310193, 32'h00418213};
    b2b_wa = '{3'd1, 3'd2, 3'd3, 3'd4};
    b2b_wd = '{8'd1, 8'd3, 8'd6, 8'd10};

    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    repeat (3) @(negedge clk);

    chk("rst.ready", 32'(bus.instr_ready), 32'd1);
    chk("rst.ra",    32'({bus.register_address1, bus.register_address2}), 32'd0);
    chk("rst.flags", 32'({bus.done, bus.illegal, bus.write_enable}), 32'd0);
    chk("rst.wa_wd", 32'({bus.write_address, bus.write_data}), 32'd0);
    chk("rst.count", 32'(bus.retired_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.ready", 32'(bus.instr_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      rf[tbl[i].ir[22:20]] = tbl[i].v2;
      rf[tbl[i].ir[17:15]] = tbl[i].v1;
      run_instr(tbl[i].ir, tbl[i].ill, tbl[i].we, tbl[i].wa, tbl[i].wd, $sformatf("vec%0d", i));
    end

    // Reset in EXECUTE while a second instruction is held valid.
    rf[1] = 8'h05;
    rf[2] = 8'h03;
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h002081B3;
    @(posedge clk);
    @(negedge clk);
    bus.instr = 32'h40208233;
    chk("rstx.dec_ready", 32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    chk("rstx.ex_ready", 32'(bus.instr_ready), 32'd0);
    chk("rstx.ex_flags", 32'({bus.done, bus.write_enable}), 32'd0);
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("rstx.ready", 32'(bus.instr_ready), 32'd1);
    chk("rstx.flags", 32'({bus.done, bus.illegal, bus.write_enable}), 32'd0);
    rst     = 1'b0;
    exp_cnt = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      chk("rstx.idle_flags", 32'({bus.done, bus.illegal, bus.write_enable}), 32'd0);
      chk("rstx.idle_ready", 32'(bus.instr_ready), 32'd1);
    end
    chk("rstx.count", 32'(bus.retired_count), 32'd0);

    // Back-to-back dependent ADDIs with valid held high throughout.
    rf[1] = 8'h00;
    k = 0;
    w = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = b2b_ir[0];
    for (int c = 0; c < 40 && w < 4; c++) begin
      if (bus.write_enable === 1'b1) begin
        chk($sformatf("b2b%0d.addr", w), 32'(bus.write_address), 32'(b2b_wa[w]));
        chk($sformatf("b2b%0d.data", w), 32'(bus.write_data), 32'(b2b_wd[w]));
        rf[b2b_wa[w]] = b2b_wd[w];
        exp_cnt = exp_cnt + 16'd1;
        w++;
      end
      accepting = (bus.instr_ready === 1'b1) && (k < 4);
      if (accepting) acc[k] = c;
      @(posedge clk);
      @(negedge clk);
      if (accepting) begin
        k++;
        if (k < 4) bus.instr = b2b_ir[k];
        else bus.instr_valid = 1'b0;
      end
    end
    chk("b2b.writes", 32'(w), 32'd4);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b.spacing%0d", i), 32'(acc[i+1] - acc[i]), 32'd4);
`ifdef INSTR_COUNTER_EN
    chk("b2b.count", 32'(bus.retired_count), 32'd4);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    exp_cnt = 16'hFFFF;
    chk("wrap.forced", 32'(bus.retired_count), 32'h0000FFFF);
    run_instr(32'h00100013, 1'b0, 1'b0, 3'd0, 8'h00, "wrap");
`else
    chk("b2b.count", 32'(bus.retired_count), 32'd0);
`endif

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ir;
      if (i % 16 == 0)
        for (int j = 0; j < 8; j++) rf[j] = 8'($urandom);
      ir = rnd_instr();
      e  = model(ir);
      run_instr(ir, e.ill, e.we, e.wa, e.wd, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
